// File: rtl/spi_expander_master_if.sv
// Host-side request/response bundle plus the four SPI pins of the expander link.
// The master modport is the controller's view; slave is the host/expander side.
interface spi_expander_master_if;
  logic       startReq;
  logic       rwIn;
  logic [3:0] addrIn;
  logic [7:0] wrData;
  logic       busy;
  logic       done;
  logic [7:0] rdData;
  logic       csN;
  logic       sclk;
  logic       mosi;
  logic       miso;

  modport master (
    input  startReq, rwIn, addrIn, wrData, miso,
    output busy, done, rdData, csN, sclk, mosi
  );

  modport slave (
    output startReq, rwIn, addrIn, wrData, miso,
    input  busy, done, rdData, csN, sclk, mosi
  );
endinterface

// File: rtl/spi_expander_master.sv
// SPI mode-0 master issuing 16-bit read/write frames to an I/O expander.
// Frame timeline: SETUP, 32 SCLK half-periods, HOLD, then a deselect GAP.
module spi_expander_master #(
  parameter int CLK_DIV = 4
) (
  input logic                   clk,
  input logic                   rstN,
  spi_expander_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} stateT;

  stateT       state;
  stateT       nextState;
  logic [7:0]  divCnt;
  logic        divLast;
  logic [4:0]  edgeCnt;
  logic [15:0] frame;
  logic [14:0] txFrame;
  logic [7:0]  rxByte;
  logic        rwLatched;
  logic        sclkQ;
  logic        mosiQ;
  logic        doneQ;
  logic [7:0]  rdQ;

  assign frame   = {bus.rwIn, bus.addrIn, 3'b000, bus.rwIn ? 8'h00 : bus.wrData};
  assign divLast = (divCnt == 8'(CLK_DIV - 1));

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic: every non-idle phase ends on a divider wrap
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (bus.startReq) nextState = SETUP;
      SETUP: if (divLast) nextState = SHIFT;
      SHIFT: if (divLast && edgeCnt == 5'd31) nextState = HOLD;
      HOLD:  if (divLast) nextState = GAP;
      GAP:   if (divLast) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    bus.busy = (state != IDLE);
    bus.csN  = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
  end

  // Divider, shift registers and the registered pins; only the data byte of
  // the receive stream is kept since the header half carries no read data
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      divCnt    <= 8'd0;
      edgeCnt   <= 5'd0;
      txFrame   <= 15'd0;
      rxByte    <= 8'd0;
      rwLatched <= 1'b0;
      sclkQ     <= 1'b0;
      mosiQ     <= 1'b0;
      doneQ     <= 1'b0;
      rdQ       <= 8'd0;
    end else begin
      doneQ <= 1'b0;
      if (state == IDLE) begin
        divCnt  <= 8'd0;
        edgeCnt <= 5'd0;
        sclkQ   <= 1'b0;
        if (bus.startReq) begin
          txFrame   <= frame[14:0];
          rwLatched <= bus.rwIn;
          mosiQ     <= frame[15];
        end else begin
          mosiQ <= 1'b0;
        end
      end else begin
        divCnt <= divLast ? 8'd0 : divCnt + 8'd1;
        if (state == SHIFT && divLast) begin
          sclkQ   <= ~sclkQ;
          edgeCnt <= edgeCnt + 5'd1;
          if (!sclkQ) begin
            rxByte <= {rxByte[6:0], bus.miso};
          end else if (edgeCnt != 5'd31) begin
            mosiQ   <= txFrame[14];
            txFrame <= {txFrame[13:0], 1'b0};
          end
        end
        if (state == HOLD && divLast) mosiQ <= 1'b0;
        if (state == GAP && divLast) begin
          doneQ <= 1'b1;
          if (rwLatched) rdQ <= rxByte;
        end
      end
    end
  end

  assign bus.sclk   = sclkQ;
  assign bus.mosi   = mosiQ;
  assign bus.done   = doneQ;
  assign bus.rdData = rdQ;

endmodule

// File: tb/tb_spi_expander_master.sv
// Scoreboard bench for spi_expander_master: one instance at CLK_DIV=4, one at
// CLK_DIV=1, each with an expander model on miso and a done-triggered monitor.
module tb_spi_expander_master;

  typedef struct {
    int          inst;
    logic [15:0] mosi;
    logic [7:0]  rd;
    int          cyc;
  } expT;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  startV;
  logic        rwV;
  logic [3:0]  addrV;
  logic [7:0]  wrV;
  logic [15:0] misoWord;
  logic        expectGap;
  logic [1:0]  busyW;
  logic [1:0]  sclkW;
  expT         sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  spi_expander_master_if bus[2] ();

  spi_expander_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rstN(rstN), .bus(bus[0]));
  spi_expander_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rstN(rstN), .bus(bus[1]));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D = (g == 0) ? 4 : 1;
    int          cyc;
    int          rises;
    int          runLen;
    logic [15:0] bits;
    logic        prevBusy, prevCs, prevSclk, prevDone;
    logic        sawRise = 1'b0;
    logic [15:0] sr;
    expT         e;

    assign bus[g].startReq = startV[g];
    assign bus[g].rwIn     = rwV;
    assign bus[g].addrIn   = addrV;
    assign bus[g].wrData   = wrV;
    assign busyW[g]        = bus[g].busy;
    assign sclkW[g]        = bus[g].sclk;

    // Expander model: loads its response on select, shifts on SCLK falling edges
    always @(negedge bus[g].csN or posedge bus[g].sclk or negedge bus[g].sclk) begin
      if (bus[g].sclk) begin
        sawRise = 1'b1;
      end else if (sawRise) begin
        sawRise = 1'b0;
        sr = {sr[14:0], 1'b0};
        bus[g].miso = sr[15];
      end else if (!bus[g].csN) begin
        sr = misoWord;
        bus[g].miso = sr[15];
      end
    end

    // Monitor: collects mosi at SCLK rises, times the frame, checks on done
    always @(negedge clk) begin
      if (!rstN) begin
        cyc = 0; rises = 0; bits = '0; runLen = 0;
        prevBusy = 1'b0; prevCs = 1'b1; prevSclk = 1'b0; prevDone = 1'b0;
      end else begin
        if (bus[g].busy && !prevBusy) begin
          cyc = 0; rises = 0; bits = '0;
        end else begin
          cyc++;
        end
        if (bus[g].sclk && !prevSclk) begin
          rises++;
          bits = {bits[14:0], bus[g].mosi};
        end
        if (bus[g].csN != prevCs) begin
          if (bus[g].csN) begin
            checkOutput("csN low length", runLen, 34 * D);
            checkOutput("mosi at deselect", bus[g].mosi, 0);
            checkOutput("sclk at deselect", bus[g].sclk, 0);
          end else if (expectGap) begin
            // GAP deselect plus the IDLE cycle in which done is shown
            checkOutput("csN gap length", runLen, D + 1);
          end
          runLen = 1;
        end else begin
          runLen++;
        end
        if (prevDone) checkOutput("done width", bus[g].done, 0);
        if (bus[g].done) begin
          if (sb.size() == 0) begin
            checkOutput("spurious done", bus[g].done, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("done lane", g, e.inst);
            checkOutput("mosi frame", bits, e.mosi);
            checkOutput("sclk rises", rises, 16);
            checkOutput("done cycle", cyc, e.cyc);
            checkOutput("rdData", bus[g].rdData, e.rd);
            checkOutput("busy at done", bus[g].busy, 0);
          end
        end
        prevBusy = bus[g].busy;
        prevCs   = bus[g].csN;
        prevSclk = bus[g].sclk;
        prevDone = bus[g].done;
      end
    end
  end

  task automatic pushExpect(input int inst, input logic [15:0] expMosi, input logic [7:0] expRd);
    expT e;
    e.inst = inst;
    e.mosi = expMosi;
    e.rd   = expRd;
    e.cyc  = 35 * ((inst == 0) ? 4 : 1);
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int inst, input logic rw, input logic [3:0] addr,
                               input logic [7:0] data, input logic [15:0] resp);
    @(negedge clk);
    misoWord = resp; rwV = rw; addrV = addr; wrV = data; startV[inst] = 1'b1;
    @(negedge clk);
    startV[inst] = 1'b0;
  endtask

  task automatic waitIdle(input int inst);
    int n = 0;
    while (busyW[inst] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busyW[inst]) checkOutput("busy timeout", busyW[inst], 0);
    @(negedge clk);
  endtask

  initial begin
    int   n;
    int   k;
    logic prev;
    rstN = 1'b0; startV = 2'b00; rwV = 1'b0; addrV = 4'h0; wrV = 8'h00;
    misoWord = 16'h0000; expectGap = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset csN", bus[0].csN, 1);
    checkOutput("reset sclk", bus[0].sclk, 0);
    checkOutput("reset mosi", bus[0].mosi, 0);
    checkOutput("reset busy", bus[0].busy, 0);
    checkOutput("reset done", bus[0].done, 0);
    checkOutput("reset rdData", bus[0].rdData, 0);
    rstN = 1'b1;

    $display("[TB] write addr 5 data A3");
    pushExpect(0, 16'h28A3, 8'h00);
    applyStimulus(0, 1'b0, 4'h5, 8'hA3, 16'h00EE);
    waitIdle(0);

    $display("[TB] read addr F, expander returns 5C");
    pushExpect(0, 16'hF800, 8'h5C);
    applyStimulus(0, 1'b1, 4'hF, 8'h00, 16'h005C);
    waitIdle(0);

    $display("[TB] read addr 3 with stray start pulses mid-frame");
    pushExpect(0, 16'h9800, 8'hA7);
    applyStimulus(0, 1'b1, 4'h3, 8'h00, 16'h00A7);
    rwV = 1'b0; addrV = 4'hA; wrV = 8'hFF;
    repeat (3) @(negedge clk);
    startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    repeat (55) @(negedge clk);
    startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    waitIdle(0);

    $display("[TB] startReq held high for three back-to-back writes");
    repeat (3) pushExpect(0, 16'h103C, 8'hA7);
    @(negedge clk);
    misoWord = 16'h00C3; rwV = 1'b0; addrV = 4'h2; wrV = 8'h3C; startV[0] = 1'b1;
    repeat (2) @(negedge clk);
    expectGap = 1'b1;
    n = 0; k = 0;
    while (n < 2 && k < 1000) begin
      @(negedge clk);
      k++;
      if (bus[0].done) n++;
    end
    @(negedge clk);
    startV[0] = 1'b0;
    waitIdle(0);
    expectGap = 1'b0;

    $display("[TB] reset after the 7th SCLK rise of a read");
    applyStimulus(0, 1'b1, 4'h7, 8'h00, 16'h1234);
    n = 0; k = 0; prev = 1'b0;
    while (n < 7 && k < 500) begin
      @(negedge clk);
      k++;
      if (sclkW[0] && !prev) n++;
      prev = sclkW[0];
    end
    rstN = 1'b0;
    #1;
    checkOutput("abort csN", bus[0].csN, 1);
    checkOutput("abort sclk", bus[0].sclk, 0);
    checkOutput("abort mosi", bus[0].mosi, 0);
    checkOutput("abort busy", bus[0].busy, 0);
    checkOutput("abort done", bus[0].done, 0);
    checkOutput("abort rdData", bus[0].rdData, 0);
    repeat (2) @(negedge clk);
    pushExpect(0, 16'hE000, 8'h81);
    misoWord = 16'h0081; rwV = 1'b1; addrV = 4'hC; wrV = 8'h00; startV[0] = 1'b1;
    rstN = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    checkOutput("start right after reset", busyW[0], 1);
    waitIdle(0);

    $display("[TB] CLK_DIV=1 write addr 5 data A3");
    pushExpect(1, 16'h28A3, 8'h00);
    applyStimulus(1, 1'b0, 4'h5, 8'hA3, 16'h00EE);
    waitIdle(1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
